// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flushes and data-memory freezes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic        IF_ID_UseRs1,
    input  logic        IF_ID_UseRs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_MemRead,
    input  logic        EX_BranchTaken,
    input  logic        EX_MEM_MemAccess,
    input  logic        dmem_ready,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        CTRL_SELECT,
    output logic        ID_EX_Write,
    output logic        EX_MEM_Write,
    output logic [1:0]  hz_state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] freeze_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } hzState_t;

    localparam logic [2:0] LU_LOAD    = 3'(LU_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    generate
        if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 7) begin : gLuRangeErr
            $error("hazard_ctrl: LU_STALL_CYCLES must be in 1..7");
        end
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : gFlushRangeErr
            $error("hazard_ctrl: FLUSH_CYCLES must be in 1..7");
        end
    endgenerate

    hzState_t   stateReg, stateNext;
    logic [2:0] cntReg, cntNext;
    logic       hold, lu;
    logic       pcWr, ifIdWr, ifIdFl, ctrlSel, idExWr, exMemWr;

    assign hold = EX_MEM_MemAccess & ~dmem_ready;
    assign lu   = ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                  ((IF_ID_UseRs1 & (IF_ID_rs1 == ID_EX_rd)) |
                   (IF_ID_UseRs2 & (IF_ID_rs2 == ID_EX_rd)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateReg <= RUN;
            cntReg   <= 3'd0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        pcWr      = 1'b1;
        ifIdWr    = 1'b1;
        ifIdFl    = 1'b0;
        ctrlSel   = 1'b1;
        idExWr    = 1'b1;
        exMemWr   = 1'b1;
        if (hold) begin
            // Memory freeze: nothing moves, pending hazards are seen again once unheld.
            pcWr    = 1'b0;
            ifIdWr  = 1'b0;
            idExWr  = 1'b0;
            exMemWr = 1'b0;
        end else begin
            case (stateReg)
                RUN: begin
                    if (EX_BranchTaken) begin
                        ifIdFl  = 1'b1;
                        ctrlSel = 1'b0;
                        if (FLUSH_CYCLES > 1) begin
                            stateNext = FLUSH;
                            cntNext   = FLUSH_LOAD;
                        end
                    end else if (lu) begin
                        pcWr    = 1'b0;
                        ifIdWr  = 1'b0;
                        ctrlSel = 1'b0;
                        if (LU_STALL_CYCLES > 1) begin
                            stateNext = LU_STALL;
                            cntNext   = LU_LOAD;
                        end
                    end
                end
                LU_STALL: begin
                    pcWr    = 1'b0;
                    ifIdWr  = 1'b0;
                    ctrlSel = 1'b0;
                    if (cntReg <= 3'd1) begin
                        stateNext = RUN;
                        cntNext   = 3'd0;
                    end else begin
                        cntNext = cntReg - 3'd1;
                    end
                end
                FLUSH: begin
                    ifIdFl  = 1'b1;
                    ctrlSel = 1'b0;
                    if (cntReg <= 3'd1) begin
                        stateNext = RUN;
                        cntNext   = 3'd0;
                    end else begin
                        cntNext = cntReg - 3'd1;
                    end
                end
                default: begin
                    stateNext = RUN;
                    cntNext   = 3'd0;
                end
            endcase
        end
    end

    // Every output, including CTRL_SELECT, is forced low while reset is held.
    assign PCWrite      = rstn & pcWr;
    assign IF_ID_Write  = rstn & ifIdWr;
    assign IF_ID_Flush  = rstn & ifIdFl;
    assign CTRL_SELECT  = rstn & ctrlSel;
    assign ID_EX_Write  = rstn & idExWr;
    assign EX_MEM_Write = rstn & exMemWr;
    assign hz_state     = rstn ? stateReg : RUN;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCntReg, flushCntReg, freezeCntReg;
    logic        stallEv;

    // A load-use bubble is an unheld cycle that squashes control without a flush.
    assign stallEv = ~hold & ~ctrlSel & ~ifIdFl;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stallCntReg  <= 32'd0;
            flushCntReg  <= 32'd0;
            freezeCntReg <= 32'd0;
        end else begin
            if (stallEv && stallCntReg != 32'hFFFF_FFFF)
                stallCntReg <= stallCntReg + 32'd1;
            if (ifIdFl && flushCntReg != 32'hFFFF_FFFF)
                flushCntReg <= flushCntReg + 32'd1;
            if (hold && freezeCntReg != 32'hFFFF_FFFF)
                freezeCntReg <= freezeCntReg + 32'd1;
        end
    end

    assign stall_cnt  = stallCntReg;
    assign flush_cnt  = flushCntReg;
    assign freeze_cnt = freezeCntReg;
`else
    assign stall_cnt  = 32'd0;
    assign flush_cnt  = 32'd0;
    assign freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one default instance and one with LU_STALL_CYCLES=3, FLUSH_CYCLES=2.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  rs1, rs2, rd;
    logic        useRs1, useRs2, memRead, brTaken, memAccess, dmemReady;

    logic        pcA, ifwA, flA, csA, idexA, exmA;
    logic [1:0]  stA;
    logic [31:0] stallA, flushA, freezeA;
    logic        pcB, ifwB, flB, csB, idexB, exmB;
    logic [1:0]  stB;
    logic [31:0] stallB, flushB, freezeB;

    // Packed output order: PCWrite, IF_ID_Write, IF_ID_Flush, CTRL_SELECT, ID_EX_Write, EX_MEM_Write, hz_state
    localparam logic [7:0] RST  = 8'h00;
    localparam logic [7:0] NRM  = 8'hDC;
    localparam logic [7:0] BUB  = 8'h0C;
    localparam logic [7:0] BUB1 = 8'h0D;
    localparam logic [7:0] FLU  = 8'hEC;
    localparam logic [7:0] FLU2 = 8'hEE;
    localparam logic [7:0] HLD  = 8'h10;
    localparam logic [7:0] HLD1 = 8'h11;

    typedef struct packed {
        logic [7:0] expA;
        logic [7:0] expB;
        int         id;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    int checks = 0;
    int passed = 0;
    int vecId  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dutA (
        .clk(clk), .rstn(rstn),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_UseRs1(useRs1), .IF_ID_UseRs2(useRs2),
        .ID_EX_rd(rd), .ID_EX_MemRead(memRead), .EX_BranchTaken(brTaken),
        .EX_MEM_MemAccess(memAccess), .dmem_ready(dmemReady),
        .PCWrite(pcA), .IF_ID_Write(ifwA), .IF_ID_Flush(flA), .CTRL_SELECT(csA),
        .ID_EX_Write(idexA), .EX_MEM_Write(exmA), .hz_state(stA),
        .stall_cnt(stallA), .flush_cnt(flushA), .freeze_cnt(freezeA)
    );

    hazard_ctrl #(.LU_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dutB (
        .clk(clk), .rstn(rstn),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_UseRs1(useRs1), .IF_ID_UseRs2(useRs2),
        .ID_EX_rd(rd), .ID_EX_MemRead(memRead), .EX_BranchTaken(brTaken),
        .EX_MEM_MemAccess(memAccess), .dmem_ready(dmemReady),
        .PCWrite(pcB), .IF_ID_Write(ifwB), .IF_ID_Flush(flB), .CTRL_SELECT(csB),
        .ID_EX_Write(idexB), .EX_MEM_Write(exmB), .hz_state(stB),
        .stall_cnt(stallB), .flush_cnt(flushB), .freeze_cnt(freezeB)
    );

    // Apply one cycle of inputs just after the edge and queue the expected outputs.
    task automatic cyc(input logic rn, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] d, input logic mr,
                       input logic br, input logic ma, input logic rdy,
                       input logic [7:0] eA, input logic [7:0] eB);
        sbEntry_t e;
        @(posedge clk);
        #1;
        rstn = rn; rs1 = r1; rs2 = r2; useRs1 = u1; useRs2 = u2; rd = d;
        memRead = mr; brTaken = br; memAccess = ma; dmemReady = rdy;
        e.expA = eA; e.expB = eB; e.id = vecId;
        sbQ.push_back(e);
        vecId++;
    endtask

    task automatic idle(input logic [7:0] eA, input logic [7:0] eB);
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, eA, eB);
    endtask

    task automatic cmp(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        // IF_ID_Write is don't-care while IF/ID is being flushed.
        logic [7:0] mask;
        mask = exp[5] ? 8'hBF : 8'hFF;
        checks++;
        if ((act & mask) === (exp & mask))
            passed++;
        else
            $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle on the falling edge.
    initial begin
        sbEntry_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                cmp("dutA", e.id, {pcA, ifwA, flA, csA, idexA, exmA, stA}, e.expA);
                cmp("dutB", e.id, {pcB, ifwB, flB, csB, idexB, exmB, stB}, e.expB);
                $display("vec %0d: A=%h B=%h", e.id, {pcA, ifwA, flA, csA, idexA, exmA, stA},
                         {pcB, ifwB, flB, csB, idexB, exmB, stB});
            end
        end
    end

    initial begin
        rstn = 1'b0; rs1 = 0; rs2 = 0; rd = 0; useRs1 = 0; useRs2 = 0;
        memRead = 0; brTaken = 0; memAccess = 0; dmemReady = 0;

        // Reset state
        cyc(1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RST, RST);
        cyc(1'b0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, RST, RST);
        idle(NRM, NRM);

        // Load-use on rs1: A bubbles once, B bubbles three times (states 0,1,1,0)
        cyc(1'b1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, BUB, BUB);
        idle(NRM, BUB1);
        idle(NRM, BUB1);
        idle(NRM, NRM);

        // Destination x0 never stalls
        cyc(1'b1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, NRM, NRM);
        // Unused source or non-load never stalls
        cyc(1'b1, 5'd0, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0, NRM, NRM);
        cyc(1'b1, 5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, NRM, NRM);
        // Load-use on rs2
        cyc(1'b1, 5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, BUB, BUB);
        idle(NRM, BUB1);
        idle(NRM, BUB1);
        idle(NRM, NRM);

        // Taken branch: A flushes 1 cycle, B flushes 2
        cyc(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, FLU, FLU);
        idle(NRM, FLU2);
        idle(NRM, NRM);

        // Freeze beats load-use for 4 cycles, then the hazard resolves
        repeat (4) cyc(1'b1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0, HLD, HLD);
        cyc(1'b1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 1, BUB, BUB);
        // Freeze inside LU_STALL keeps the count
        cyc(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, HLD, HLD1);
        idle(NRM, BUB1);
        idle(NRM, BUB1);
        idle(NRM, NRM);

        // Freeze beats branch; access with ready is no freeze
        cyc(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, HLD, HLD);
        cyc(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, FLU, FLU);
        cyc(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, NRM, FLU2);
        idle(NRM, NRM);

        // Async reset in the middle of B's flush
        cyc(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, FLU, FLU);
        cyc(1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RST, RST);
        idle(NRM, NRM);
        idle(NRM, NRM);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbQ.size() == 0)
            passed++;
        else
            $display("FAIL drain: %0d entries left, expected 0", sbQ.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Branch must never reach EX while in LU_STALL or FLUSH.
    always @(negedge clk) begin
        if (rstn && brTaken && ((stA != 2'd0 && memAccess == 1'b0) || (stB != 2'd0 && memAccess == 1'b0))) begin
            checks++;
            $display("FAIL branch_in_stall: state A=%0d B=%0d, expected RUN", stA, stB);
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage CPU.
- Decides each cycle whether the ID/EX control bundle passes or is replaced by a bubble (drives CTRL_SELECT of the ID/EX control mux).
- Gates PC, IF/ID, ID/EX and EX/MEM register writes.
- Handles load-use stalls, taken-branch flushes and data-memory wait freezes, with parameterised multi-cycle penalties.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- IF_ID_rs1  in  5  source register 1 of the instruction in ID.
- IF_ID_rs2  in  5  source register 2 of the instruction in ID.
- IF_ID_UseRs1  in  1  instruction in ID reads rs1.
- IF_ID_UseRs2  in  1  instruction in ID reads rs2.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX.
- EX_MEM_MemAccess  in  1  instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes access this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  IF/ID clear to NOP (dominates IF_ID_Write).
- CTRL_SELECT  out  1  1 = pass control bundle, 0 = bubble.
- ID_EX_Write  out  1  ID/EX load enable.
- EX_MEM_Write  out  1  EX/MEM load enable.
- hz_state  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 FLUSH.

Behaviour:
- Clock and reset: one clock (clk); reset rstn is asynchronous and active-low.
- During reset: state = RUN, counter cnt (3 bits) = 0.
- While rstn = 0, all outputs are 0, including CTRL_SELECT.
- Outputs are combinational from state, cnt and inputs; state and cnt are registered.
- hold = EX_MEM_MemAccess & ~dmem_ready.
- lu = ID_EX_MemRead & (ID_EX_rd != 0) & ((IF_ID_UseRs1 & IF_ID_rs1 == ID_EX_rd) | (IF_ID_UseRs2 & IF_ID_rs2 == ID_EX_rd)).
- Priority is hold > branch > load-use.
- hold (any state): all write enables = 0, IF_ID_Flush = 0, CTRL_SELECT = 1. State and cnt do not change.
- RUN with EX_BranchTaken:
  - PCWrite = 1, IF_ID_Flush = 1, CTRL_SELECT = 0; ID_EX_Write = 1, EX_MEM_Write = 1.
  - If FLUSH_CYCLES > 1: go to FLUSH with cnt = FLUSH_CYCLES - 1. Otherwise stay in RUN.
- RUN with lu:
  - PCWrite = 0, IF_ID_Write = 0, CTRL_SELECT = 0; ID_EX_Write = 1, EX_MEM_Write = 1.
  - If LU_STALL_CYCLES > 1: go to LU_STALL with cnt = LU_STALL_CYCLES - 1.
- RUN otherwise: all enables = 1, CTRL_SELECT = 1, IF_ID_Flush = 0.
- LU_STALL:
  - Outputs as for RUN-lu. cnt decrements each unheld cycle; when cnt = 1, return to RUN next cycle.
  - lu is not re-evaluated while in LU_STALL.
- FLUSH:
  - Outputs as for RUN-branch. cnt decrements; when cnt = 1, return to RUN.
- EX_BranchTaken in LU_STALL or FLUSH: impossible (EX holds a bubble). It is ignored, no state change; the bench flags it as an error.
- hold asserted on the same cycle as branch or lu: the freeze wins. The hazard is re-evaluated on the first unheld cycle.
- Reset mid-stall or mid-flush: immediate return to RUN with cnt = 0.
- Out-of-range parameter values: elaboration error via a generate-time check.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Enabled: adds output ports stall_cnt, flush_cnt and freeze_cnt, each 32 bits, saturating at 0xFFFFFFFF, cleared by rstn.
  - stall_cnt increments on each cycle with a load-use bubble.
  - flush_cnt increments on each cycle with IF_ID_Flush = 1.
  - freeze_cnt increments on each hold cycle.
- Disabled: the same ports are present and tied to 0; no counter logic.

Test Plan:
- Load-use, defaults: ID_EX_MemRead = 1, ID_EX_rd = 5, IF_ID_rs1 = 5, UseRs1 = 1 → exactly 1 cycle of PCWrite = 0, IF_ID_Write = 0, CTRL_SELECT = 0, then all = 1.
- rd = x0: ID_EX_rd = 0, rs1 = 0, load in EX → no stall, CTRL_SELECT = 1.
- LU_STALL_CYCLES = 3: same hazard → 3 consecutive bubble cycles; hz_state sequence RUN, 1, 1, RUN.
- Branch with FLUSH_CYCLES = 2: EX_BranchTaken = 1 for one cycle → IF_ID_Flush = 1 and CTRL_SELECT = 0 for 2 cycles; PCWrite = 1 throughout.
- Freeze priority: lu and hold both = 1 for 4 cycles, then dmem_ready = 1 → 4 cycles with all enables 0, then 1 bubble cycle.
- Async reset: rstn low mid-FLUSH, then released → outputs 0 during reset, hz_state = 0 on release, next cycle normal RUN outputs.
